// File: rtl/eth_tx_scheduler.sv
// Transmit sequencer: fetches one frame byte-by-byte from the single-ported TX buffer RAM,
// hands each byte to the serializer, then holds off for the inter-frame gap before reporting done.
module eth_tx_scheduler #(
  parameter int ADDR_W     = 10,
  parameter int IFG_CYCLES = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  input  logic              cpu_go,
  input  logic [ADDR_W:0]   cpu_len,
  input  logic              cpu_abort,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] buf_a,
  output logic              buf_we,
  output logic              buf_re,
  output logic [7:0]        buf_wdata,
  input  logic [7:0]        buf_rdata,
  input  logic              ser_ready,
  output logic              ser_load,
  output logic [7:0]        ser_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        state_dbg
);

  localparam int GAP_W = (IFG_CYCLES < 2) ? 1 : $clog2(IFG_CYCLES + 1);
  localparam logic [ADDR_W:0]   LEN_ONE = 1;
  localparam logic [ADDR_W-1:0] PTR_ONE = 1;
  localparam logic [GAP_W-1:0]  GAP_ONE = 1;
  localparam logic [GAP_W-1:0]  GAP_INIT = GAP_W'(IFG_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_LATCH    = 3'd2,
    S_WAIT_SER = 3'd3,
    S_GAP      = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   len;
  logic [GAP_W-1:0]  gap_cnt;
  logic              len_ok;
  logic              last_byte;
  logic              go_req;
  logic              kill;

  // Legal lengths are 1..2**ADDR_W: nonzero, and if the top bit is set nothing below it may be.
  assign len_ok    = (cpu_len != '0) && (!cpu_len[ADDR_W] || (cpu_len[ADDR_W-1:0] == '0));
  assign last_byte = ({1'b0, ptr} == (len - LEN_ONE));
  assign go_req    = cpu_go && !cpu_abort;
  assign kill      = rst || cpu_abort;

  // Transmit fetches own the RAM port only in FETCH; every other cycle the CPU write goes straight through.
  assign cpu_stall = cpu_we && (state == S_FETCH);
  assign buf_we    = cpu_we && !cpu_stall && !rst;
  assign buf_a     = (state == S_FETCH) ? ptr : cpu_addr;
  assign buf_wdata = cpu_wdata;
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    buf_re    = 1'b0;
    ser_load  = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE:     if (go_req && len_ok) state_nxt = S_FETCH;
      S_FETCH: begin
        buf_re    = 1'b1;
        state_nxt = S_LATCH;
      end
      S_LATCH:    state_nxt = S_WAIT_SER;
      S_WAIT_SER: if (ser_ready) begin
        ser_load  = 1'b1;
        state_nxt = last_byte ? S_GAP : S_FETCH;
      end
      S_GAP:      if (gap_cnt == '0) begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default:    state_nxt = S_IDLE;
    endcase
    // Abort and reset abandon the frame without a final handoff or completion pulse.
    if (kill) begin
      state_nxt = S_IDLE;
      ser_load  = 1'b0;
      done      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      len      <= '0;
      gap_cnt  <= '0;
      ser_data <= '0;
      err      <= 1'b0;
    end else begin
      if (go_req) begin
        if ((state == S_IDLE) && len_ok) begin
          len <= cpu_len;
          ptr <= '0;
          err <= 1'b0;
        end else begin
          err <= 1'b1;
        end
      end
      if (state == S_LATCH) ser_data <= buf_rdata;
      if (ser_load && !last_byte) ptr <= ptr + PTR_ONE;
      if (ser_load && last_byte) gap_cnt <= GAP_INIT;
      else if ((state == S_GAP) && (gap_cnt != '0)) gap_cnt <= gap_cnt - GAP_ONE;
    end
  end

endmodule
